// File: rtl/posit_pkg.sv
// Shared defaults and result payload layout for the posit multiplier issue stage.
package posit_pkg;

   localparam int unsigned N_DEF     = 8;
   localparam int unsigned LAT_DEF   = 3;
   localparam int unsigned DEPTH_DEF = 8;

   // One buffered multiplier result at the default posit width.
   typedef struct packed {
      logic             nar;
      logic [N_DEF-1:0] p;
   } posit_res_t;

endpackage

// File: rtl/posit_res_fifo.sv
// First-word fall-through result FIFO; pointers wrap modulo DEPTH (power of two).
module posit_res_fifo
   import posit_pkg::*;
#(
   parameter int unsigned W     = N_DEF + 1,
   parameter int unsigned DEPTH = DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [W-1:0]             data_i,
   output logic [W-1:0]             data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];

   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/posit_mul_issue.sv
// Issues operand pairs to a fixed-latency posit multiplier and buffers results in order,
// admitting a new pair only when a FIFO slot is guaranteed for its result.
module posit_mul_issue
   import posit_pkg::*;
#(
   parameter int unsigned N     = N_DEF,
   parameter int unsigned LAT   = LAT_DEF,
   parameter int unsigned DEPTH = DEPTH_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_a,
   input  logic [N-1:0] in_b,
   output logic [N-1:0] mul_a,
   output logic [N-1:0] mul_b,
   input  logic [N-1:0] mul_p,
   input  logic         mul_nar,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_p,
   output logic         out_nar,
   output logic [7:0]   nar_count,
   output logic         busy
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned SW = CW + 1;

   typedef struct packed {
      logic         nar;
      logic [N-1:0] p;
   } res_t;

   logic           fire, push, pop;
   logic           fifo_full, fifo_empty;
   logic [CW-1:0]  fifo_count;
   logic [SW-1:0]  inflight;
   logic [LAT-1:0] vld_q, vld_d;
   logic [7:0]     nar_cnt_q, nar_cnt_d;
   res_t           wr_res, rd_res;

   // Credit check uses registered state only, so in_ready never sees in_valid or out_ready.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < int'(LAT); i++) inflight = inflight + SW'(vld_q[i]);
   end

   assign in_ready = (SW'(fifo_count) + inflight) < SW'(DEPTH);
   assign fire     = in_valid && in_ready;
   assign mul_a    = fire ? in_a : '0;
   assign mul_b    = fire ? in_b : '0;

   assign push   = vld_q[LAT-1];
   assign wr_res = '{nar: mul_nar, p: mul_p};

   assign out_valid = !fifo_empty;
   assign pop       = out_valid && out_ready;
   assign out_p     = rd_res.p;
   assign out_nar   = rd_res.nar;
   assign nar_count = nar_cnt_q;
   assign busy      = (vld_q != '0) || (fifo_count != '0);

   posit_res_fifo #(
      .W     ($bits(res_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  (wr_res),
      .data_o  (rd_res),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   always_comb begin
      vld_d     = LAT'({vld_q, fire});
      nar_cnt_d = nar_cnt_q;
      if (pop && out_nar && (nar_cnt_q != 8'hFF)) nar_cnt_d = nar_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q     <= '0;
         nar_cnt_q <= '0;
      end else begin
         vld_q     <= vld_d;
         nar_cnt_q <= nar_cnt_d;
      end
   end

   // The credit scheme must never let a multiplier result arrive at a full FIFO.
   no_dropped_result: assert property (@(posedge clk) disable iff (rst)
      !(push && fifo_full && !pop));

endmodule

// File: tb/tb_posit_mul_issue.sv
// Randomized scoreboard bench for posit_mul_issue with a 3-stage multiplier stand-in.
module tb_posit_mul_issue;
   import posit_pkg::*;

   localparam int unsigned N     = 8;
   localparam int unsigned DEPTH = 8;
   localparam int          VIS   = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready;
   logic [N-1:0] in_a, in_b, mul_a, mul_b, mul_p;
   logic         mul_nar;
   logic         out_valid, out_ready, out_nar, busy;
   logic [N-1:0] out_p;
   logic [7:0]   nar_count;

   posit_mul_issue #(.N(N), .LAT(3), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_p     (mul_p),
      .mul_nar   (mul_nar),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p     (out_p),
      .out_nar   (out_nar),
      .nar_count (nar_count),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Multiplier stand-in: exact for NaR, zero and one; deterministic scramble otherwise.
   function automatic posit_res_t ref_mul(input logic [7:0] a, input logic [7:0] b);
      posit_res_t r;
      if (a == 8'h80 || b == 8'h80)      r = '{nar: 1'b1, p: 8'h80};
      else if (a == 8'h00 || b == 8'h00) r = '{nar: 1'b0, p: 8'h00};
      else if (a == 8'h40)               r = '{nar: 1'b0, p: b};
      else if (b == 8'h40)               r = '{nar: 1'b0, p: a};
      else                               r = '{nar: 1'b0, p: 8'(a * b) ^ 8'h5A};
      return r;
   endfunction

   posit_res_t m1_q, m2_q, m3_q;
   always_ff @(posedge clk) begin
      m1_q <= ref_mul(mul_a, mul_b);
      m2_q <= m1_q;
      m3_q <= m2_q;
   end
   assign mul_p   = m3_q.p;
   assign mul_nar = m3_q.nar;

   typedef struct {
      posit_res_t r;
      int         vis;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   outstanding = 0;
   int   nar_exp = 0;
   int   fire_cnt = 0;
   int   pop_cnt = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every cycle compares handshake/status outputs and the FIFO head against the model.
   initial begin
      bit exp_ready, exp_valid, fire;
      forever begin
         @(negedge clk);
         if (rst) begin
            sb.delete();
            outstanding = 0;
            nar_exp     = 0;
            chk("rst_out_valid", 32'(out_valid), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_nar_count", 32'(nar_count), 0);
            chk("rst_mul_a", 32'(mul_a), 0);
            continue;
         end
         exp_ready = (outstanding < int'(DEPTH));
         fire      = in_valid && exp_ready;
         exp_valid = (sb.size() > 0) && (sb[0].vis <= cyc);
         chk("in_ready", 32'(in_ready), 32'(exp_ready));
         chk("out_valid", 32'(out_valid), 32'(exp_valid));
         chk("busy", 32'(busy), 32'(outstanding != 0));
         chk("nar_count", 32'(nar_count), nar_exp);
         chk("mul_a", 32'(mul_a), fire ? 32'(in_a) : 0);
         chk("mul_b", 32'(mul_b), fire ? 32'(in_b) : 0);
         if (exp_valid) begin
            chk("out_p", 32'(out_p), 32'(sb[0].r.p));
            chk("out_nar", 32'(out_nar), 32'(sb[0].r.nar));
            if (out_ready) begin
               if (sb[0].r.nar && nar_exp < 255) nar_exp++;
               void'(sb.pop_front());
               outstanding--;
               pop_cnt++;
            end
         end
         if (fire) begin
            sb.push_back('{r: ref_mul(in_a, in_b), vis: cyc + VIS});
            outstanding++;
            fire_cnt++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [7:0] a, input logic [7:0] b);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      tick();
      in_valid = 1'b0;
   endtask

   function automatic logic [7:0] rnd_posit();
      case ($urandom % 8)
         0:       return 8'h80;
         1:       return 8'h00;
         2:       return 8'h40;
         default: return 8'($urandom);
      endcase
   endfunction

   task automatic drain(input string tag);
      out_ready = 1'b1;
      for (int k = 0; k < 400 && sb.size() != 0; k++) tick();
      chk(tag, sb.size(), 0);
   endtask

   initial begin
      int f0, p0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      repeat (2) tick();
      chk("idle_in_ready", 32'(in_ready), 1);

      // Single op 1.0 * 1.0
      issue(8'h40, 8'h40);
      repeat (6) tick();
      chk("single_popped", pop_cnt, 1);

      // NaR result held under backpressure, then popped
      out_ready = 1'b0;
      issue(8'h80, 8'h40);
      repeat (6) tick();
      chk("nar_held_count", 32'(nar_count), 0);
      out_ready = 1'b1;
      repeat (2) tick();
      chk("nar_single", 32'(nar_count), 1);

      // Backpressure: continuous offers with consumer stalled
      out_ready = 1'b0;
      f0 = fire_cnt;
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1;
         in_a     = rnd_posit();
         in_b     = rnd_posit();
         tick();
      end
      in_valid = 1'b0;
      chk("bp_fires", fire_cnt - f0, 8);
      chk("bp_in_ready_low", 32'(in_ready), 0);
      drain("bp_drain");

      // Streaming 100 back-to-back ops
      f0 = fire_cnt;
      p0 = pop_cnt;
      for (int i = 0; i < 100; i++) begin
         in_valid = 1'b1;
         in_a     = rnd_posit();
         in_b     = rnd_posit();
         tick();
      end
      in_valid = 1'b0;
      chk("stream_fires", fire_cnt - f0, 100);
      drain("stream_drain");
      chk("stream_pops", pop_cnt - p0, 100);

      // Random traffic with random consumer stalls
      for (int i = 0; i < 600; i++) begin
         in_valid  = ($urandom % 3) != 0;
         out_ready = ($urandom % 4) != 0;
         in_a      = rnd_posit();
         in_b      = rnd_posit();
         tick();
      end
      in_valid = 1'b0;
      drain("random_drain");

      // Reset with three results buffered and two in the pipeline
      out_ready = 1'b0;
      issue(8'h11, 8'h22);
      issue(8'h33, 8'h44);
      issue(8'h80, 8'h55);
      tick();
      issue(8'h66, 8'h77);
      issue(8'h80, 8'h80);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      p0 = pop_cnt;
      repeat (10) tick();
      chk("post_rst_no_stale", pop_cnt - p0, 0);
      issue(8'h40, 8'h23);
      drain("post_rst_drain");
      chk("post_rst_one_pop", pop_cnt - p0, 1);

      // Saturation: 300 NaR results
      for (int i = 0; i < 300; i++) begin
         in_valid = 1'b1;
         in_a     = 8'h80;
         in_b     = rnd_posit();
         tick();
      end
      in_valid = 1'b0;
      drain("sat_drain");
      chk("nar_sat", 32'(nar_count), 255);
      repeat (2) tick();
      chk("final_busy", 32'(busy), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
